// File: rtl/arb_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant_sequencer
// Description : Captures a request vector as a batch and grants each set bit
//               once, lowest index first, over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant_sequencer #(
   parameter int N   = 16,
   parameter int IDW = 4,
   parameter int CW  = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_in,
   input  logic           flush,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   input  logic           gnt_ready,
   output logic [N-1:0]   pending,
   output logic           busy,
   output logic [CW-1:0]  served_count,
   output logic           batch_done
);

   localparam logic [N-1:0]  c_one_n  = N'(1);
   localparam logic [CW-1:0] c_one_cw = CW'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SERVE = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [N-1:0]    r_pending, w_pending_nxt;
   logic [CW-1:0]   r_served, w_served_nxt;
   logic            r_done, w_done_nxt;
   logic [N-1:0]    w_lowbit;
   logic [N-1:0]    w_remain;
   logic [IDW-1:0]  w_lowid;
   logic            w_serving;

   // Isolate the lowest set bit; pending is never zero while serving.
   assign w_lowbit  = r_pending & ~(r_pending - c_one_n);
   assign w_remain  = r_pending & ~w_lowbit;
   assign w_serving = (r_state == S_SERVE);

   always_comb begin
      w_lowid = '0;
      for (int i = 0; i < N; i++) begin
         if (w_lowbit[i]) w_lowid = IDW'(i);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_served_nxt  = r_served;
      w_done_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!flush && (req_in != '0)) begin
               w_pending_nxt = req_in;
               w_served_nxt  = '0;
               w_state_nxt   = S_SERVE;
            end
         end
         S_SERVE: begin
            // Flush takes precedence over a same-cycle acceptance.
            if (flush) begin
               w_pending_nxt = '0;
               w_state_nxt   = S_IDLE;
            end else if (gnt_ready) begin
               w_pending_nxt = w_remain;
               w_served_nxt  = r_served + c_one_cw;
               if (w_remain == '0) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_served  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_served  <= w_served_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign gnt_valid    = w_serving;
   assign gnt          = w_serving ? w_lowbit : '0;
   assign gnt_id       = w_serving ? w_lowid : '0;
   assign pending      = r_pending;
   assign busy         = w_serving;
   assign served_count = r_served;
   assign batch_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_arb_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_grant_sequencer
// Description : Directed bench with a batch-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_grant_sequencer;

   logic        clk = 1'b0;
   logic        rst, flush, gnt_ready;
   logic [15:0] req_in;
   logic [15:0] gnt, pending;
   logic [3:0]  gnt_id;
   logic        gnt_valid, busy, batch_done;
   logic [4:0]  served_count;

   arb_grant_sequencer #(.N(16), .IDW(4), .CW(5)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .flush(flush),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
      .pending(pending), .busy(busy), .served_count(served_count),
      .batch_done(batch_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Reference model: a set of outstanding requests plus a count of grants
   logic [15:0] m_pending;
   bit          m_busy, m_done;
   int          m_served;

   always @(posedge clk) begin
      if (rst) begin
         m_pending = '0; m_busy = 0; m_done = 0; m_served = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (!flush && req_in != 0) begin
               m_pending = req_in; m_served = 0; m_busy = 1;
            end
         end else if (flush) begin
            m_pending = '0; m_busy = 0;
         end else if (gnt_ready) begin
            m_pending[lowest(m_pending)] = 1'b0;
            m_served++;
            if (m_pending == 0) begin
               m_busy = 0; m_done = 1;
            end
         end
      end
   end

   logic [15:0] log_g[$];
   logic [3:0]  log_id[$];
   int          done_cnt, serve_cyc;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("gnt", 32'(gnt), m_busy ? (32'd1 << lowest(m_pending)) : 32'd0);
         chk("gnt_id", 32'(gnt_id), m_busy ? 32'(lowest(m_pending)) : 32'd0);
         chk("pending", 32'(pending), 32'(m_pending));
         chk("served_count", 32'(served_count), 32'(m_served));
         chk("batch_done", 32'(batch_done), 32'(m_done));
         if (gnt_valid && gnt_ready && !flush && !rst) begin
            log_g.push_back(gnt);
            log_id.push_back(gnt_id);
         end
         if (batch_done) done_cnt++;
         if (busy) serve_cyc++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      log_g.delete(); log_id.delete(); done_cnt = 0; serve_cyc = 0;
   endtask

   logic [15:0] e2_g[7]  = '{16'h0004, 16'h0010, 16'h0100, 16'h0200, 16'h0400, 16'h1000, 16'h2000};
   int          e2_id[7] = '{2, 4, 8, 9, 10, 12, 13};

   initial begin
      rst = 1; req_in = 0; flush = 0; gnt_ready = 0;
      @(posedge clk); #1;
      cmp_en = 1;
      chk("rst_valid", 32'(gnt_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_served", 32'(served_count), 0);
      chk("rst_done", 32'(batch_done), 0);
      rst = 0;
      repeat (5) step();
      chk("idle_busy", 32'(busy), 0);

      // Sparse batch with constant acceptance
      clear_logs();
      req_in = 16'h3714; gnt_ready = 1; step();
      req_in = 0; repeat (10) step();
      chk("t2_len", 32'(log_g.size()), 7);
      for (int i = 0; i < 7 && i < log_g.size(); i++) begin
         chk("t2_gnt", 32'(log_g[i]), 32'(e2_g[i]));
         chk("t2_id", 32'(log_id[i]), 32'(e2_id[i]));
      end
      chk("t2_served", 32'(served_count), 7);
      chk("t2_done_cnt", 32'(done_cnt), 1);
      chk("t2_serve_cyc", 32'(serve_cyc), 7);

      // Full batch with toggling ready
      clear_logs();
      req_in = 16'hFFFF; gnt_ready = 1; step();
      req_in = 0;
      for (int k = 1; k < 40; k++) begin
         gnt_ready = (k % 2 == 0);
         step();
      end
      gnt_ready = 0;
      chk("t3_len", 32'(log_id.size()), 16);
      for (int i = 0; i < 16 && i < log_id.size(); i++)
         chk("t3_id", 32'(log_id[i]), 32'(i));
      chk("t3_served", 32'(served_count), 16);
      chk("t3_serve_cyc", 32'(serve_cyc), 32);
      chk("t3_done_cnt", 32'(done_cnt), 1);

      // Back-to-back batches; req_in ignored while serving
      clear_logs();
      req_in = 16'h0001; gnt_ready = 1; step();
      req_in = 16'h8000; step(); step();
      gnt_ready = 0; req_in = 16'h00FF; step(); step();
      chk("t4_pending", 32'(pending), 32'h8000);
      chk("t4_gnt", 32'(gnt), 32'h8000);
      chk("t4_id", 32'(gnt_id), 15);
      gnt_ready = 1; req_in = 0; step();
      repeat (3) step();
      chk("t4_len", 32'(log_g.size()), 2);
      if (log_g.size() == 2) begin
         chk("t4_g0", 32'(log_g[0]), 32'h0001);
         chk("t4_g1", 32'(log_g[1]), 32'h8000);
      end
      chk("t4_done_cnt", 32'(done_cnt), 2);
      chk("t4_served", 32'(served_count), 1);

      // Flush together with ready after two grants
      clear_logs();
      req_in = 16'h00F0; gnt_ready = 1; step();
      req_in = 0; step(); step();
      flush = 1; step();
      flush = 0; gnt_ready = 0;
      chk("t5_pending", 32'(pending), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_served", 32'(served_count), 2);
      step();
      chk("t5_done_cnt", 32'(done_cnt), 0);
      chk("t5_len", 32'(log_g.size()), 2);

      // Reset during an accepted grant
      clear_logs();
      req_in = 16'h0300; gnt_ready = 0; step();
      req_in = 0;
      chk("t6_valid_pre", 32'(gnt_valid), 1);
      chk("t6_gnt_pre", 32'(gnt), 32'h0100);
      rst = 1; gnt_ready = 1; step();
      rst = 0; gnt_ready = 0;
      chk("t6_valid", 32'(gnt_valid), 0);
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_pending", 32'(pending), 0);
      chk("t6_served", 32'(served_count), 0);
      chk("t6_done", 32'(batch_done), 0);
      step();
      chk("t6_done_cnt", 32'(done_cnt), 0);

      // Flush in IDLE blocks capture
      req_in = 16'h0055; flush = 1; step();
      flush = 0; req_in = 0;
      chk("t7_busy", 32'(busy), 0);
      chk("t7_pending", 32'(pending), 0);
      step();

      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
